// File: rtl/debounce_sync.sv
// Two/three/four-flop synchronizer followed by a run-length debounce FSM with registered level and edge pulses.
// Optional DEBOUNCE_EDGE_CNT_EN adds an 8-bit wrapping count of accepted rising edges on edge_cnt.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in1,
  output logic       out,
  output logic       rise,
  output logic       fall,
  output logic       busy
`ifdef DEBOUNCE_EDGE_CNT_EN
  ,
  output logic [7:0] edge_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   s;

  // in1 only ever enters through the first synchronizer flop
  assign sync_d = {sync_q[SYNC_STAGES-2:0], in1};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          out_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          out_d   = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
    // busy is registered from the next state so it equals a decode of the state register
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_EDGE_CNT_EN
  logic [7:0] edge_cnt_q, edge_cnt_d;

  // counts accepted rising edges, wraps naturally at 8 bits
  assign edge_cnt_d = rise_d ? edge_cnt_q + 8'd1 : edge_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= 8'd0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: hand table, corner sequences and random bounce vs a run-length model.
module tb_debounce_sync;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  logic clk    = 1'b0;
  logic clk_en = 1'b1;
  logic rst    = 1'b1;
  logic in1    = 1'b0;
  logic out, rise, fall, busy;
`ifdef DEBOUNCE_EDGE_CNT_EN
  logic [7:0] edge_cnt;
`endif

  always #5 if (clk_en) clk = ~clk;

  debounce_sync #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .in1 (in1),
    .out (out),
    .rise(rise),
    .fall(fall),
    .busy(busy)
`ifdef DEBOUNCE_EDGE_CNT_EN
    ,
    .edge_cnt(edge_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference: in1 seen SYNC edges late; out flips after DEB consecutive samples differing from out
  bit         mq[$];
  int         run;
  bit         m_out, m_rise, m_fall;
  logic [7:0] m_ecnt;

  function automatic void m_reset();
    mq.delete();
    for (int i = 0; i < int'(SYNC); i++) mq.push_back(1'b0);
    run    = 0;
    m_out  = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_ecnt = 8'd0;
  endfunction

  function automatic void m_edge(bit v);
    bit smp;
    if (rst) begin
      m_reset();
      return;
    end
    smp = mq.pop_front();
    mq.push_back(v);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (smp != m_out) begin
      run++;
      if (run == int'(DEB)) begin
        m_out = smp;
        run   = 0;
        if (smp) begin
          m_rise = 1'b1;
          m_ecnt = m_ecnt + 8'd1;
        end else begin
          m_fall = 1'b1;
        end
      end
    end else begin
      run = 0;
    end
  endfunction

  function automatic logic [3:0] dut_vec();
    return {out, rise, fall, busy};
  endfunction

  function automatic logic [3:0] mdl_vec();
    return {m_out, m_rise, m_fall, (run > 0)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Drive in1 for one clock, update the model on the edge, compare on the falling edge
  task automatic step(input bit v, input string name);
    in1 = v;
    @(posedge clk);
    m_edge(v);
    @(negedge clk);
    check(name, 32'(dut_vec()), 32'(mdl_vec()));
    check({name, "_excl"}, 32'(rise & fall), 32'd0);
`ifdef DEBOUNCE_EDGE_CNT_EN
    check({name, "_ecnt"}, 32'(edge_cnt), 32'(m_ecnt));
`endif
  endtask

  typedef struct {
    bit         v;
    logic [3:0] exp;   // {out, rise, fall, busy}
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit v, logic [3:0] e);
    vec_t x;
    x.v   = v;
    x.exp = e;
    tbl.push_back(x);
  endfunction

  initial begin
    int n_pulse, idx, hold;
    bit cur;
    bit pat[7];

    m_reset();

    // reset with in1 high: everything stays at zero
    in1 = 1'b1;
    #2;
    check("rst_initial", 32'(dut_vec()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, "rst_hold");
      check("rst_hold_zero", 32'(dut_vec()), 32'd0);
    end
    clk_en = 1'b0;
    #15;
    check("rst_noclk", 32'(dut_vec()), 32'd0);
    #15;
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // clean rise, clean fall, 3-sample glitch, 4-sample pulse
    for (int i = 0; i < 5; i++) add(1'b1, (i < 2) ? 4'b0000 : 4'b0001);
    add(1'b1, 4'b1100); add(1'b1, 4'b1000);
    add(1'b0, 4'b1000); add(1'b0, 4'b1000);
    add(1'b0, 4'b1001); add(1'b0, 4'b1001); add(1'b0, 4'b1001);
    add(1'b0, 4'b0010); add(1'b0, 4'b0000);
    add(1'b1, 4'b0000); add(1'b1, 4'b0000); add(1'b1, 4'b0001);
    add(1'b0, 4'b0001); add(1'b0, 4'b0001); add(1'b0, 4'b0000); add(1'b0, 4'b0000);
    add(1'b1, 4'b0000); add(1'b1, 4'b0000); add(1'b1, 4'b0001); add(1'b1, 4'b0001);
    add(1'b0, 4'b0001); add(1'b0, 4'b1100); add(1'b0, 4'b1001); add(1'b0, 4'b1001);
    add(1'b0, 4'b1001); add(1'b0, 4'b0010); add(1'b0, 4'b0000);
    foreach (tbl[i]) begin
      step(tbl[i].v, "tbl_model");
      check($sformatf("tbl_%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end

    // bounce on fall: out must drop only after the last four consecutive zeros
    for (int i = 0; i < 6; i++) step(1'b1, "bounce_pre");
    check("bounce_pre_out", 32'(out), 32'd1);
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    n_pulse = 0;
    idx     = -1;
    for (int i = 0; i < 10; i++) begin
      step((i < 7) ? pat[i] : 1'b0, "bounce");
      if (fall) begin
        n_pulse++;
        idx = i;
      end
    end
    check("bounce_fall_count", 32'(n_pulse), 32'd1);
    check("bounce_fall_idx", 32'(idx), 32'd8);
    check("bounce_out", 32'(out), 32'd0);

    // async reset while qualifying a rise with cnt==2, clock stopped
    for (int i = 0; i < 4; i++) step(1'b1, "midwait");
    check("midwait_busy", 32'(busy), 32'd1);
    clk_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst", 32'(dut_vec()), 32'd0);
    m_reset();
    #18 clk_en = 1'b1;
    step(1'b1, "midwait_rst");
    rst = 1'b0;
    n_pulse = 0;
    idx     = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, "requal");
      if (rise) begin
        n_pulse++;
        idx = i;
      end
    end
    check("requal_rise_count", 32'(n_pulse), 32'd1);
    check("requal_rise_idx", 32'(idx), 32'd5);

    // random bouncing input with occasional resets
    cur = 1'b1;
    for (int i = 0; i < 300; i++) begin
      hold = int'($urandom_range(1, 7));
      cur  = ~cur;
      for (int j = 0; j < hold; j++) begin
        rst = ($urandom_range(0, 399) == 0);
        step(cur, "rand");
      end
    end
    rst = 1'b0;

`ifdef DEBOUNCE_EDGE_CNT_EN
    rst = 1'b1;
    step(1'b0, "ec_rst");
    rst = 1'b0;
    check("ec_zero", 32'(edge_cnt), 32'd0);
    for (int i = 0; i < 257; i++) begin
      for (int j = 0; j < 6; j++) step(1'b1, "ec_hi");
      for (int j = 0; j < 6; j++) step(1'b0, "ec_lo");
    end
    check("ec_wrap", 32'(edge_cnt), 32'd1);
    rst = 1'b1;
    #1;
    check("ec_async_clr", 32'(edge_cnt), 32'd0);
    m_reset();
    step(1'b0, "ec_rst2");
    rst = 1'b0;
    for (int j = 0; j < 6; j++) step(1'b1, "ec_hi2");
    for (int j = 0; j < 6; j++) step(1'b0, "ec_lo2");
    check("ec_after_fall", 32'(edge_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Input-conditioning stage that sits directly upstream of the Buffer gate and drives its in1.
- Synchronizes an asynchronous raw input (switch, button or external pin) into the clk domain and debounces it.
- Produces a clean level plus single-cycle rise/fall pulses for downstream logic-gate and RISC-core consumers.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops ahead of the debounce FSM; legal 2..4.
DEBOUNCE_CYCLES, 4, consecutive synchronized samples required to accept a new level; legal >= 2.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
in1  input  1  raw asynchronous input.
out  output 1  debounced, synchronized level; feeds Buffer.in1.
rise  output 1  one-cycle pulse when out goes 0->1.
fall  output 1  one-cycle pulse when out goes 1->0.
busy  output 1  high while a candidate level change is being qualified.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset: sync chain all 0, state STABLE_LO, cnt 0, out 0, rise 0, fall 0, busy 0. Applies immediately on rst assertion, independent of clk.
- Synchronizer: SYNC_STAGES-deep shift chain, sync[0] <= in1. s = last stage. in1 is never used anywhere else.
- Internal counter width: clog2(DEBOUNCE_CYCLES+1) bits. The counter never exceeds DEBOUNCE_CYCLES-1.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
- STABLE_LO:
  - s=1: go to WAIT_HI, cnt <= 1.
  - Otherwise stay.
- WAIT_HI:
  - s=0: go to STABLE_LO, cnt <= 0 (glitch rejected, no pulse).
  - s=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI, out <= 1, rise <= 1, cnt <= 0.
  - Otherwise cnt++.
- STABLE_HI / WAIT_LO: mirror of the above with polarity inverted. Acceptance sets out <= 0 and fall <= 1.
- rise/fall: registered pulses, high exactly one cycle, deasserted the next cycle. Never both high in the same cycle.
- busy: high exactly when state is WAIT_HI or WAIT_LO (decoded from registered state).
- Latency: in1 changes before edge E0 and stays stable. out and the pulse update at edge E(SYNC_STAGES+DEBOUNCE_CYCLES-1), i.e. E5 with defaults.
- Pulses: a pulse of s shorter than DEBOUNCE_CYCLES consecutive samples never changes out. A pulse of exactly DEBOUNCE_CYCLES samples is accepted.
- Bounce during WAIT_*: any sample equal to out returns to the STABLE state and clears cnt. Qualification restarts from 1 on the next opposing sample.
- rst mid-WAIT: state, cnt and out return to reset values. Pending qualification is discarded and no pulse is emitted.
- in1 held at 1 through reset release: out rises E(SYNC_STAGES+DEBOUNCE_CYCLES-1) edges after the first post-reset edge, with one rise pulse.
- No combinational path from in1 to any output.

Optional Feature:
- Macro: DEBOUNCE_EDGE_CNT_EN.
- Defined: adds output port edge_cnt (output, 8 bits).
  - Increments by 1 in the same edge that asserts rise.
  - Wraps 255 -> 0.
  - Reset value 0; cleared asynchronously by rst.
  - fall does not affect it.
- Undefined: edge_cnt port and its counter do not exist. All other behaviour is identical.

Test Plan:
- Reset: rst=1 with in1=1 for 3 cycles -> out=0, rise=0, fall=0, busy=0 throughout (and during any clk-free interval while rst=1).
- Clean rise, defaults: rst released, in1 0->1 before E0 and held -> busy high from E2; out=1 and rise=1 after E5; rise=0 after E6; out stays 1.
- Glitch rejection: in1 high for 3 cycles then low -> out stays 0, rise never asserts, busy high 3 cycles then 0. Repeat with 4 cycles -> out=1 with exactly one rise pulse.
- Bounce on fall: out=1, then in1 pattern 0,0,1,0,0,0,0 (one per cycle) -> out falls only after the final four consecutive 0 samples propagate; exactly one fall pulse.
- Reset mid-operation: in1 rises, assert rst when busy=1 with cnt=2 -> out=0, busy=0 immediately; no rise pulse appears after reset release until in1 is requalified.
- DEBOUNCE_EDGE_CNT_EN defined: 257 clean rising transitions -> edge_cnt=1 (wrapped). rst -> edge_cnt=0. 10 falls with no rises -> edge_cnt unchanged.
